// File: rtl/imem_loader_if.sv
// Byte-stream, instruction-memory write and status signals of the instruction-memory loader.
// The loader takes the slave side; whoever feeds the stream and watches the status takes master.
interface imem_loader_if #(
  parameter int ADDR_W  = 6,
  parameter int INSTR_W = 19
);
  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_ready;
  logic               restart;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_wdata;
  logic               cpu_reset;
  logic               done;
  logic               error;
  logic [1:0]         err_code;

  modport master (
    output in_valid, in_data, restart,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, error, err_code
  );

  modport slave (
    input  in_valid, in_data, restart,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_reset, done, error, err_code
  );
endinterface

// File: rtl/imem_loader.sv
// Loads 19-bit instruction words from a checksummed byte stream into the processor's
// instruction memory, and holds the processor in reset until a load completes cleanly.
module imem_loader #(
  parameter int ADDR_W  = 6,
  parameter int INSTR_W = 19
) (
  input  logic        clk,
  input  logic        reset,
  imem_loader_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_B0, S_B1, S_B2, S_CHK, S_DONE, S_ERR} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] wdata_q, wdata_d;
  logic               we_q, we_d;
  logic [7:0]         csum_q, csum_d;
  logic [2:0]         hi_q, hi_d;
  logic [7:0]         mid_q, mid_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [1:0]         code_q, code_d;
  logic               in_ready;
  logic               accept;

  assign in_ready = (state_q != S_DONE) && (state_q != S_ERR);
  assign accept   = bus.in_valid && in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      csum_q  <= '0;
      hi_q    <= '0;
      mid_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      csum_q  <= csum_d;
      hi_q    <= hi_d;
      mid_q   <= mid_d;
      done_q  <= done_d;
      error_q <= error_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    csum_d  = csum_q;
    hi_d    = hi_q;
    mid_d   = mid_q;
    done_d  = done_q;
    error_d = error_q;
    code_d  = code_q;
    // The address advances the cycle after each write strobe; 6-bit wrap only follows a full load.
    addr_d  = we_q ? addr_q + ADDR_W'(1) : addr_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          csum_d = csum_q ^ bus.in_data;
          if (int'(bus.in_data) > DEPTH) begin
            state_d = S_ERR;
            error_d = 1'b1;
            code_d  = 2'b01;
          end else begin
            cnt_d   = (bus.in_data == 8'd0) ? CNT_W'(DEPTH) : CNT_W'(bus.in_data);
            state_d = S_B0;
          end
        end
      end
      S_B0: begin
        if (accept) begin
          if (bus.in_data[7:3] != 5'd0) begin
            state_d = S_ERR;
            error_d = 1'b1;
            code_d  = 2'b10;
          end else begin
            csum_d  = csum_q ^ bus.in_data;
            hi_d    = bus.in_data[2:0];
            state_d = S_B1;
          end
        end
      end
      S_B1: begin
        if (accept) begin
          csum_d  = csum_q ^ bus.in_data;
          mid_d   = bus.in_data;
          state_d = S_B2;
        end
      end
      S_B2: begin
        if (accept) begin
          csum_d  = csum_q ^ bus.in_data;
          wdata_d = INSTR_W'({hi_q, mid_q, bus.in_data});
          we_d    = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = (cnt_q == CNT_W'(1)) ? S_CHK : S_B0;
        end
      end
      S_CHK: begin
        if (accept) begin
          if (bus.in_data == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
            code_d  = 2'b11;
          end
        end
      end
      S_DONE, S_ERR: begin
        if (bus.restart) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
          error_d = 1'b0;
          code_d  = 2'b00;
          addr_d  = '0;
          csum_d  = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_reset = (state_q != S_DONE);
  assign bus.done      = done_q;
  assign bus.error     = error_q;
  assign bus.err_code  = code_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good loads, each error class, paced input, full 64-word load, mid-load reset.
module tb_imem_loader;
  localparam int ADDR_W  = 6;
  localparam int INSTR_W = 19;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus();

  imem_loader #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [ADDR_W-1:0]  wa[$];
  logic [INSTR_W-1:0] wd[$];

  always @(negedge clk) begin
    if (reset && bus.mem_we) begin
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_wdata);
    end
  end

  logic [7:0]         s1 [7] = '{8'h02, 8'h01, 8'h23, 8'h45, 8'h07, 8'hFF, 8'hFF};
  logic [INSTR_W-1:0] s1_words [2] = '{19'h12345, 19'h7FFFF};

  task automatic send_byte(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
  endtask

  task automatic go_idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_restart();
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] obs;
    obs = {bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.cpu_reset,
           bus.done, bus.error, bus.err_code};
    checks++;
    if (obs !== {1'b1, 1'b0, 6'd0, 19'd0, 1'b1, 1'b0, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", obs,
               {1'b1, 1'b0, 6'd0, 19'd0, 1'b1, 1'b0, 1'b0, 2'b00});
    end
  endtask

  task automatic test_basic();
    wa.delete(); wd.delete();
    for (int i = 0; i < 7; i++) send_byte(s1[i]);
    send_byte(8'h62);
    checks++;
    if (bus.done !== 1'b1 || bus.cpu_reset !== 1'b0 || bus.error !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: done=%b cpu_reset=%b error=%b required 1 0 0",
               bus.done, bus.cpu_reset, bus.error);
    end
    // keep offering bytes while DONE: they must be ignored
    send_byte(8'h55);
    send_byte(8'h01);
    go_idle(1);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.done !== 1'b1 || bus.mem_addr !== 6'd2) begin
      errors++;
      $display("FAIL basic_after: in_ready=%b done=%b addr=%0d required 0 1 2",
               bus.in_ready, bus.done, bus.mem_addr);
    end
    checks++;
    if (wa.size() !== 2) begin
      errors++;
      $display("FAIL basic_write_count: got %0d required 2", wa.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (wa[i] !== ADDR_W'(i) || wd[i] !== s1_words[i]) begin
          errors++;
          $display("FAIL basic_write%0d: addr=%0d data=%h required %0d %h",
                   i, wa[i], wd[i], i, s1_words[i]);
        end
      end
    end
    pulse_restart();
  endtask

  task automatic test_bad_checksum();
    wa.delete(); wd.delete();
    for (int i = 0; i < 7; i++) send_byte(s1[i]);
    send_byte(8'h63);
    go_idle(1);
    checks++;
    if (bus.error !== 1'b1 || bus.err_code !== 2'b11 || bus.cpu_reset !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL bad_csum_status: error=%b code=%b cpu_reset=%b done=%b required 1 11 1 0",
               bus.error, bus.err_code, bus.cpu_reset, bus.done);
    end
    checks++;
    if (wa.size() !== 2 || wd.size() !== 2 || wd[0] !== s1_words[0] || wd[1] !== s1_words[1]) begin
      errors++;
      $display("FAIL bad_csum_writes: count=%0d required 2 with %h %h", wa.size(),
               s1_words[0], s1_words[1]);
    end
    pulse_restart();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.mem_addr !== 6'd0 || bus.error !== 1'b0 ||
        bus.err_code !== 2'b00 || bus.cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL restart_clear: ready=%b addr=%0d error=%b code=%b cpu_reset=%b required 1 0 0 00 1",
               bus.in_ready, bus.mem_addr, bus.error, bus.err_code, bus.cpu_reset);
    end
  endtask

  task automatic test_bad_count();
    wa.delete(); wd.delete();
    send_byte(8'h41);
    go_idle(0);
    checks++;
    if (bus.error !== 1'b1 || bus.err_code !== 2'b01 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bad_count: error=%b code=%b ready=%b required 1 01 0",
               bus.error, bus.err_code, bus.in_ready);
    end
    go_idle(2);
    checks++;
    if (wa.size() !== 0) begin
      errors++;
      $display("FAIL bad_count_writes: got %0d required 0", wa.size());
    end
    pulse_restart();
  endtask

  task automatic test_bad_format();
    wa.delete(); wd.delete();
    send_byte(8'h01);
    send_byte(8'h08);
    go_idle(0);
    checks++;
    if (bus.error !== 1'b1 || bus.err_code !== 2'b10) begin
      errors++;
      $display("FAIL bad_format: error=%b code=%b required 1 10", bus.error, bus.err_code);
    end
    go_idle(2);
    checks++;
    if (wa.size() !== 0) begin
      errors++;
      $display("FAIL bad_format_writes: got %0d required 0", wa.size());
    end
    pulse_restart();
  endtask

  task automatic test_gaps();
    wa.delete(); wd.delete();
    for (int i = 0; i < 8; i++) begin
      send_byte((i < 7) ? s1[i] : 8'h62);
      go_idle(i % 4);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.cpu_reset !== 1'b0 || bus.error !== 1'b0) begin
      errors++;
      $display("FAIL gaps_done: done=%b cpu_reset=%b error=%b required 1 0 0",
               bus.done, bus.cpu_reset, bus.error);
    end
    checks++;
    if (wa.size() !== 2 || wa[0] !== 6'd0 || wa[1] !== 6'd1 ||
        wd[0] !== s1_words[0] || wd[1] !== s1_words[1]) begin
      errors++;
      $display("FAIL gaps_writes: count=%0d required 2 writes %h@0 %h@1", wa.size(),
               s1_words[0], s1_words[1]);
    end
    pulse_restart();
  endtask

  task automatic test_full_load();
    logic [7:0]         cs;
    logic [INSTR_W-1:0] w;
    logic [23:0]        bytes;
    int                 bad;
    wa.delete(); wd.delete();
    cs = 8'h00;
    send_byte(8'h00);
    for (int i = 0; i < 64; i++) begin
      w     = INSTR_W'(i * 32'h1111);
      bytes = {5'b0, w};
      cs    = cs ^ bytes[23:16] ^ bytes[15:8] ^ bytes[7:0];
      send_byte(bytes[23:16]);
      send_byte(bytes[15:8]);
      send_byte(bytes[7:0]);
    end
    send_byte(cs);
    go_idle(1);
    checks++;
    if (bus.done !== 1'b1 || bus.error !== 1'b0 || bus.mem_addr !== 6'd0) begin
      errors++;
      $display("FAIL full_done: done=%b error=%b addr=%0d required 1 0 0",
               bus.done, bus.error, bus.mem_addr);
    end
    checks++;
    if (wa.size() !== 64) begin
      errors++;
      $display("FAIL full_write_count: got %0d required 64", wa.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 64; i++) begin
        w = INSTR_W'(i * 32'h1111);
        if (wa[i] !== ADDR_W'(i) || wd[i] !== w) begin
          if (bad == 0)
            $display("FAIL full_write%0d: addr=%0d data=%h required %0d %h", i, wa[i], wd[i], i, w);
          bad++;
        end
      end
      checks++;
      if (bad != 0) errors++;
    end
    pulse_restart();
  endtask

  task automatic test_reset_midload();
    for (int i = 0; i < 4; i++) send_byte(s1[i]);
    bus.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    test_reset();
    reset = 1'b1;
    wa.delete(); wd.delete();
    for (int i = 0; i < 7; i++) send_byte(s1[i]);
    send_byte(8'h62);
    go_idle(1);
    checks++;
    if (bus.done !== 1'b1 || bus.cpu_reset !== 1'b0) begin
      errors++;
      $display("FAIL reload_done: done=%b cpu_reset=%b required 1 0", bus.done, bus.cpu_reset);
    end
    checks++;
    if (wa.size() !== 2 || wa[0] !== 6'd0 || wa[1] !== 6'd1 ||
        wd[0] !== s1_words[0] || wd[1] !== s1_words[1]) begin
      errors++;
      $display("FAIL reload_writes: count=%0d required 2 writes from addr 0", wa.size());
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.restart  = 1'b0;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_bad_checksum();
    test_bad_count();
    test_bad_format();
    test_gaps();
    test_full_load();
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
